// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, redirects, trap vectoring,
// stall with a buffered redirect, halt/resume and misaligned-target detection.
module pc_gen #(
   parameter int unsigned          PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'h0000_0000),
   parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_01C0),
   parameter int unsigned          INSTR_BYTES  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic                trap_req,
   input  logic                halt_req,
   input  logic                resume,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [PC_WIDTH-1:0] pc_plus,
   output logic                pc_valid,
   output logic                misalign,
   output logic                halted
);

   // INSTR_BYTES is a power of two, so its low bits form the alignment mask
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
   localparam logic [PC_WIDTH-1:0] PC_INCR    = PC_WIDTH'(INSTR_BYTES);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                valid_q, valid_d;
   logic                misalign_q, misalign_d;
   logic                halted_q, halted_d;
   logic                pend_valid_q, pend_valid_d;
   logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;

   logic                eff_valid;
   logic [PC_WIDTH-1:0] eff_target;
   logic                eff_misaligned;
   logic [PC_WIDTH-1:0] redir_pc;

   // A fresh redirect always wins over the one buffered during a stall
   assign eff_valid      = redirect_valid | pend_valid_q;
   assign eff_target     = redirect_valid ? redirect_target : pend_target_q;
   assign eff_misaligned = |(eff_target & ALIGN_MASK);
   assign redir_pc       = eff_misaligned ? TRAP_VECTOR : eff_target;

   assign pc_plus = pc_q + PC_INCR;

   // Next-state and next-output selection
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      valid_d       = valid_q;
      halted_d      = halted_q;
      misalign_d    = 1'b0;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;

      case (state_q)
         ST_BOOT: begin
            state_d  = ST_RUN;
            valid_d  = 1'b1;
            halted_d = 1'b0;
         end

         ST_RUN: begin
            if (trap_req) begin
               pc_d         = TRAP_VECTOR;
               pend_valid_d = 1'b0;
            end else if (stall && redirect_valid) begin
               pend_valid_d  = 1'b1;
               pend_target_d = redirect_target;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (eff_valid) begin
               pc_d         = redir_pc;
               misalign_d   = eff_misaligned;
               pend_valid_d = 1'b0;
               if (halt_req) begin
                  state_d  = ST_HALT;
                  valid_d  = 1'b0;
                  halted_d = 1'b1;
               end
            end else if (halt_req) begin
               state_d  = ST_HALT;
               valid_d  = 1'b0;
               halted_d = 1'b1;
            end else begin
               pc_d = pc_plus;
            end
         end

         ST_HALT: begin
            if (trap_req) begin
               pc_d         = TRAP_VECTOR;
               pend_valid_d = 1'b0;
               state_d      = ST_RUN;
               valid_d      = 1'b1;
               halted_d     = 1'b0;
            end else if (redirect_valid) begin
               pc_d         = redir_pc;
               misalign_d   = eff_misaligned;
               pend_valid_d = 1'b0;
            end else if (resume) begin
               state_d  = ST_RUN;
               valid_d  = 1'b1;
               halted_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_VECTOR;
         valid_q       <= 1'b0;
         misalign_q    <= 1'b0;
         halted_q      <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
         misalign_q    <= misalign_d;
         halted_q      <= halted_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc_out   = pc_q;
   assign pc_valid = valid_q;
   assign misalign = misalign_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance for the main flows and an
// 8-bit instance near the top of the address space for wrap-around.
module tb_pc_gen;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_req;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc_out;
   logic [31:0] pc_plus;
   logic        pc_valid;
   logic        misalign;
   logic        halted;

   logic        rst8;
   logic        z_stall, z_redir, z_trap, z_halt, z_resume;
   logic [7:0]  z_target;
   logic [7:0]  pc8;
   logic [7:0]  pc8_plus;
   logic        valid8, misalign8, halted8;

   int checks;
   int errors;

   pc_gen dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_req        (trap_req),
      .halt_req        (halt_req),
      .resume          (resume),
      .pc_out          (pc_out),
      .pc_plus         (pc_plus),
      .pc_valid        (pc_valid),
      .misalign        (misalign),
      .halted          (halted)
   );

   pc_gen #(
      .PC_WIDTH     (8),
      .RESET_VECTOR (8'hF8),
      .TRAP_VECTOR  (8'hC0),
      .INSTR_BYTES  (4)
   ) dut8 (
      .clk             (clk),
      .reset           (rst8),
      .stall           (z_stall),
      .redirect_valid  (z_redir),
      .redirect_target (z_target),
      .trap_req        (z_trap),
      .halt_req        (z_halt),
      .resume          (z_resume),
      .pc_out          (pc8),
      .pc_plus         (pc8_plus),
      .pc_valid        (valid8),
      .misalign        (misalign8),
      .halted          (halted8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (pc_out !== 32'h0) begin $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); errors++; end
      checks++; if (pc_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", pc_valid); errors++; end
      checks++; if (misalign !== 1'b0) begin $display("FAIL reset_misalign: got %b expected 0", misalign); errors++; end
      checks++; if (halted !== 1'b0) begin $display("FAIL reset_halted: got %b expected 0", halted); errors++; end
      tick();
      reset = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin $display("FAIL boot_edge: got pc=%h valid=%b expected pc=0 valid=1", pc_out, pc_valid); errors++; end
      tick();
      checks++; if (pc_out !== 32'h4) begin $display("FAIL seq_1: got %h expected 4", pc_out); errors++; end
      tick();
      checks++; if (pc_out !== 32'h8) begin $display("FAIL seq_2: got %h expected 8", pc_out); errors++; end
      checks++; if (pc_plus !== 32'hC) begin $display("FAIL pc_plus: got %h expected c", pc_plus); errors++; end
   endtask

   task automatic test_stall_pending();
      stall = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h8) begin $display("FAIL stall_c1: got %h expected 8", pc_out); errors++; end
      redirect_valid = 1'b1; redirect_target = 32'h100;
      tick();
      checks++; if (pc_out !== 32'h8) begin $display("FAIL stall_c2: got %h expected 8", pc_out); errors++; end
      redirect_valid = 1'b0; redirect_target = 32'h0;
      tick();
      checks++; if (pc_out !== 32'h8) begin $display("FAIL stall_c3: got %h expected 8", pc_out); errors++; end
      stall = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h100) begin $display("FAIL pend_apply: got %h expected 100", pc_out); errors++; end
      tick();
      checks++; if (pc_out !== 32'h104) begin $display("FAIL pend_next: got %h expected 104", pc_out); errors++; end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_target = 32'h102;
      tick();
      checks++; if (pc_out !== 32'h1C0 || misalign !== 1'b1) begin $display("FAIL misalign_redir: got pc=%h mis=%b expected pc=1c0 mis=1", pc_out, misalign); errors++; end
      redirect_valid = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h1C4 || misalign !== 1'b0) begin $display("FAIL misalign_pulse: got pc=%h mis=%b expected pc=1c4 mis=0", pc_out, misalign); errors++; end
      redirect_valid = 1'b1; redirect_target = 32'h200; trap_req = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h1C0 || misalign !== 1'b0) begin $display("FAIL trap_over_redir: got pc=%h mis=%b expected pc=1c0 mis=0", pc_out, misalign); errors++; end
      redirect_valid = 1'b0; trap_req = 1'b0;
      tick();
      stall = 1'b1; trap_req = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h1C0) begin $display("FAIL trap_in_stall: got %h expected 1c0", pc_out); errors++; end
      stall = 1'b0; trap_req = 1'b0;
   endtask

   task automatic test_halt();
      redirect_valid = 1'b1; redirect_target = 32'h20;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc_out !== 32'h20) begin $display("FAIL halt_setup: got %h expected 20", pc_out); errors++; end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 32'h20) begin $display("FAIL halt_enter: got h=%b v=%b pc=%h expected h=1 v=0 pc=20", halted, pc_valid, pc_out); errors++; end
      for (int i = 0; i < 4; i++) begin
         stall = (i == 1);
         tick();
         checks++; if (pc_out !== 32'h20 || halted !== 1'b1) begin $display("FAIL halt_hold: cycle %0d got pc=%h h=%b expected pc=20 h=1", i, pc_out, halted); errors++; end
      end
      stall = 1'b0; resume = 1'b1;
      tick();
      resume = 1'b0;
      checks++; if (pc_valid !== 1'b1 || halted !== 1'b0 || pc_out !== 32'h20) begin $display("FAIL resume: got v=%b h=%b pc=%h expected v=1 h=0 pc=20", pc_valid, halted, pc_out); errors++; end
      tick();
      checks++; if (pc_out !== 32'h24) begin $display("FAIL resume_next: got %h expected 24", pc_out); errors++; end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      redirect_valid = 1'b1; redirect_target = 32'h300;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc_out !== 32'h300 || halted !== 1'b1 || pc_valid !== 1'b0) begin $display("FAIL halt_redir: got pc=%h h=%b v=%b expected pc=300 h=1 v=0", pc_out, halted, pc_valid); errors++; end
      trap_req = 1'b1;
      tick();
      trap_req = 1'b0;
      checks++; if (pc_out !== 32'h1C0 || halted !== 1'b0 || pc_valid !== 1'b1) begin $display("FAIL halt_trap: got pc=%h h=%b v=%b expected pc=1c0 h=0 v=1", pc_out, halted, pc_valid); errors++; end
   endtask

   task automatic test_back_to_back();
      redirect_valid = 1'b1; redirect_target = 32'h80; halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++; if (pc_out !== 32'h80 || halted !== 1'b1) begin $display("FAIL redir_halt: got pc=%h h=%b expected pc=80 h=1", pc_out, halted); errors++; end
      redirect_target = 32'h81;
      tick();
      redirect_valid = 1'b0;
      checks++; if (pc_out !== 32'h1C0 || misalign !== 1'b1 || halted !== 1'b1) begin $display("FAIL halt_misalign: got pc=%h mis=%b h=%b expected pc=1c0 mis=1 h=1", pc_out, misalign, halted); errors++; end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      checks++; if (pc_out !== 32'h1C0 || pc_valid !== 1'b1 || misalign !== 1'b0) begin $display("FAIL b2b_resume: got pc=%h v=%b mis=%b expected pc=1c0 v=1 mis=0", pc_out, pc_valid, misalign); errors++; end
      tick();
      checks++; if (pc_out !== 32'h1C4) begin $display("FAIL b2b_next: got %h expected 1c4", pc_out); errors++; end
   endtask

   task automatic test_reset_mid();
      redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      checks++; if (pc_out !== 32'h40) begin $display("FAIL mid_setup: got %h expected 40", pc_out); errors++; end
      stall = 1'b1; redirect_target = 32'h500;
      tick();
      redirect_valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0) begin $display("FAIL mid_reset: got pc=%h v=%b h=%b expected pc=0 v=0 h=0", pc_out, pc_valid, halted); errors++; end
      stall = 1'b0; trap_req = 1'b1;
      #2;
      reset = 1'b1;
      tick();
      trap_req = 1'b0;
      checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin $display("FAIL reboot_edge: got pc=%h v=%b expected pc=0 v=1", pc_out, pc_valid); errors++; end
      tick();
      checks++; if (pc_out !== 32'h4) begin $display("FAIL reboot_no_pend: got %h expected 4", pc_out); errors++; end
   endtask

   task automatic test_wrap();
      checks++; if (pc8 !== 8'hF8 || valid8 !== 1'b0) begin $display("FAIL wrap_reset: got pc=%h v=%b expected pc=f8 v=0", pc8, valid8); errors++; end
      rst8 = 1'b1;
      tick();
      checks++; if (pc8 !== 8'hF8 || valid8 !== 1'b1) begin $display("FAIL wrap_boot: got pc=%h v=%b expected pc=f8 v=1", pc8, valid8); errors++; end
      tick();
      checks++; if (pc8 !== 8'hFC || pc8_plus !== 8'h00) begin $display("FAIL wrap_fc: got pc=%h plus=%h expected pc=fc plus=00", pc8, pc8_plus); errors++; end
      tick();
      checks++; if (pc8 !== 8'h00) begin $display("FAIL wrap_00: got %h expected 00", pc8); errors++; end
      tick();
      checks++; if (pc8 !== 8'h04) begin $display("FAIL wrap_04: got %h expected 04", pc8); errors++; end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 32'h0;
      trap_req = 1'b0;
      halt_req = 1'b0;
      resume = 1'b0;
      rst8 = 1'b0;
      z_stall = 1'b0;
      z_redir = 1'b0;
      z_trap = 1'b0;
      z_halt = 1'b0;
      z_resume = 1'b0;
      z_target = 8'h0;

      test_reset();
      test_stall_pending();
      test_misalign();
      test_halt();
      test_back_to_back();
      test_reset_mid();
      test_wrap();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator. Successor to the fixed 32-bit PC register in the single-cycle RISC-V datapath.
- Holds the fetch address and selects the next PC from these sources: sequential increment, branch/jump redirect, trap vector, or hold.
- Adds stall, halt/resume, a pending-redirect latch and misaligned-target detection.
- Feeds instruction memory. Receives redirects from the branch/jump unit.

Parameters:
- PC_WIDTH, 32, width of all address ports and registers.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_01C0, PC loaded on trap or misaligned redirect.
- INSTR_BYTES, 4, sequential increment. Must be a power of 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- stall  input  1  hold current PC. Redirects arriving while stalled are buffered.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  PC_WIDTH  redirect destination.
- trap_req  input  1  exception/interrupt; highest priority.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- pc_out  output  PC_WIDTH  current fetch address (registered).
- pc_plus  output  PC_WIDTH  pc_out+INSTR_BYTES (combinational, modulo 2^PC_WIDTH).
- pc_valid  output  1  pc_out is a valid fetch address.
- misalign  output  1  one-cycle pulse: a redirect target was misaligned.
- halted  output  1  in HALT state.

Behaviour:
- Reset (reset==0, takes effect immediately, not on a clock edge):
  - pc_out=RESET_VECTOR; pc_valid=0; misalign=0; halted=0.
  - pending-redirect latch cleared.
  - state=BOOT.
- States: BOOT, RUN, HALT. The state is registered.
- BOOT: the first posedge after reset deasserts → pc_valid<=1, pc_out stays RESET_VECTOR, state→RUN. All other inputs are ignored on that edge.
- Effective redirect: eff_valid = redirect_valid | pend_valid. eff_target = redirect_valid ? redirect_target : pend_target. A new redirect overrides a buffered one.
- Misaligned: eff_target[log2(INSTR_BYTES)-1:0] != 0.
- RUN, per posedge, first matching rule wins:
  1. trap_req → pc_out<=TRAP_VECTOR; clear pending. Ignores stall.
  2. stall & redirect_valid → pend_valid<=1, pend_target<=redirect_target; pc_out holds.
  3. stall → pc_out holds.
  4. eff_valid → pc_out<=eff_target, or TRAP_VECTOR with misalign<=1 if the target is misaligned. Clear pending. If halt_req is also set, then state→HALT after the update.
  5. halt_req → state→HALT, pc_valid<=0, halted<=1; pc_out holds the next PC to fetch.
  6. otherwise → pc_out<=pc_plus (wraps to 0 past all-ones).
- misalign is high exactly one cycle after the offending edge, otherwise 0.
- HALT: pc_valid=0, halted=1.
  - trap_req → pc_out<=TRAP_VECTOR, state→RUN, pc_valid<=1, halted<=0.
  - else redirect_valid → pc_out updated as in rule 4 (with misalign check); stay in HALT.
  - else resume → state→RUN, pc_valid<=1, halted<=0, pc_out unchanged. A pending latch is applied on the next non-stalled RUN edge.
  - stall has no effect in HALT.
- Latency: every update is visible on pc_out one cycle after the sampling edge. pc_plus follows pc_out combinationally.
- Reset asserted mid-operation: all state is cleared immediately. The BOOT sequence repeats on release.

Test Plan:
- Release reset, no other inputs; pc_out sampled at posedges 1..4 → 0x0, 0x0, 0x4, 0x8. pc_valid rises after posedge 1. pc_plus=0xC while pc_out=0x8.
- pc_out=0x8; stall=1 for 3 cycles with redirect_valid=1, target 0x100 in the 2nd stalled cycle only → pc_out stays 0x8 for 3 cycles, then 0x100 on the first unstalled edge, then 0x104.
- Redirect to 0x102 → pc_out=0x1C0 and a one-cycle misalign pulse. Redirect to 0x200 simultaneous with trap_req → pc_out=0x1C0, no misalign.
- PC_WIDTH=8, RESET_VECTOR=8'hF8, INSTR_BYTES=4 → pc_out sequence F8, F8, FC, 00, 04 (wrap-around).
- halt_req at pc_out=0x20 → halted=1, pc_valid=0, pc_out holds 0x20 for 5 cycles. resume → pc_valid=1, then 0x20, 0x24. trap_req while halted → pc_out=0x1C0, halted=0.
- reset driven low between clock edges while pc_out=0x40 with a pending redirect → pc_out=RESET_VECTOR and pc_valid=0 immediately. After release the pending redirect is not applied and the BOOT sequence repeats.
